// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, ALU/load write ports, load-issue
// scoreboard inputs and the registered outputs.
interface reg_file_mp_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic                   I_en;
  logic [NRD*ADDR_W-1:0]  I_rd_addr;
  logic [NRD*XLEN-1:0]    O_rd_data;
  logic [NRD-1:0]         O_rd_hazard;
  logic                   I_alu_we;
  logic [ADDR_W-1:0]      I_alu_waddr;
  logic [XLEN-1:0]        I_alu_wdata;
  logic                   I_ld_we;
  logic [ADDR_W-1:0]      I_ld_waddr;
  logic [XLEN-1:0]        I_ld_wdata;
  logic                   I_ld_issue;
  logic [ADDR_W-1:0]      I_ld_issue_addr;
  logic [NREGS-1:0]       O_busy;

  modport master (
    output I_en, I_rd_addr, I_alu_we, I_alu_waddr, I_alu_wdata,
           I_ld_we, I_ld_waddr, I_ld_wdata, I_ld_issue, I_ld_issue_addr,
    input  O_rd_data, O_rd_hazard, O_busy
  );

  modport slave (
    input  I_en, I_rd_addr, I_alu_we, I_alu_waddr, I_alu_wdata,
           I_ld_we, I_ld_waddr, I_ld_wdata, I_ld_issue, I_ld_issue_addr,
    output O_rd_data, O_rd_hazard, O_busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with registered reads, load-over-ALU write priority,
// write-first bypass, optional hardwired x0 and a pending-load scoreboard.
module reg_file_mp #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int ADDR_W     = 5,
  parameter int NRD        = 2,
  parameter bit RESET_INIT = 1'b1,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  reg_file_mp_if.slave     bus
);

  logic [XLEN-1:0]     r_regs [NREGS];
  logic [NRD*XLEN-1:0] r_rd_data;
  logic [NRD-1:0]      r_rd_hazard;
  logic [NREGS-1:0]    r_busy;

  logic [ADDR_W-1:0]   w_rd_addr [NRD];
  logic [NRD*XLEN-1:0] w_rd_data;
  logic [NRD-1:0]      w_rd_hazard;
  logic                w_alu_ok;
  logic                w_ld_ok;
  logic                w_issue_ok;

  // An address is writable when it names a real register that is not x0.
  function automatic logic addr_writable(input logic [ADDR_W-1:0] a);
    logic in_range;
    in_range = ({1'b0, a} < (ADDR_W+1)'(NREGS));
    if (ZERO_REG && (a == {ADDR_W{1'b0}})) begin
      return 1'b0;
    end else begin
      return in_range;
    end
  endfunction

  // Qualify each write/issue request against enable and address validity.
  always_comb begin
    w_alu_ok   = bus.I_en & bus.I_alu_we   & addr_writable(bus.I_alu_waddr);
    w_ld_ok    = bus.I_en & bus.I_ld_we    & addr_writable(bus.I_ld_waddr);
    w_issue_ok = bus.I_en & bus.I_ld_issue & addr_writable(bus.I_ld_issue_addr);
  end

  // Per-port next read data and hazard; load bypass outranks ALU bypass.
  always_comb begin
    w_rd_data   = {(NRD*XLEN){1'b0}};
    w_rd_hazard = {NRD{1'b0}};
    for (int p = 0; p < NRD; p++) begin
      w_rd_addr[p] = bus.I_rd_addr[p*ADDR_W +: ADDR_W];
      if (!addr_writable(w_rd_addr[p])) begin
        w_rd_data[p*XLEN +: XLEN] = {XLEN{1'b0}};
        w_rd_hazard[p]            = 1'b0;
      end else begin
        if (w_ld_ok && (bus.I_ld_waddr == w_rd_addr[p])) begin
          w_rd_data[p*XLEN +: XLEN] = bus.I_ld_wdata;
        end else if (w_alu_ok && (bus.I_alu_waddr == w_rd_addr[p])) begin
          w_rd_data[p*XLEN +: XLEN] = bus.I_alu_wdata;
        end else begin
          w_rd_data[p*XLEN +: XLEN] = r_regs[w_rd_addr[p]];
        end
        // Pre-edge busy state: a same-cycle issue does not hazard this read.
        w_rd_hazard[p] = r_busy[w_rd_addr[p]] &
                         ~(bus.I_ld_we & (bus.I_ld_waddr == w_rd_addr[p]));
      end
    end
  end

  // Register array: ALU write first so a same-address load write overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        if (RESET_INIT) begin
          r_regs[i] <= XLEN'(i);
        end else begin
          r_regs[i] <= {XLEN{1'b0}};
        end
      end
    end else if (bus.I_en) begin
      if (w_alu_ok) begin
        r_regs[bus.I_alu_waddr] <= bus.I_alu_wdata;
      end
      if (w_ld_ok) begin
        r_regs[bus.I_ld_waddr] <= bus.I_ld_wdata;
      end
    end
  end

  // Scoreboard: writeback clears, then a same-address issue sets again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= {NREGS{1'b0}};
    end else if (bus.I_en) begin
      if (w_ld_ok) begin
        r_busy[bus.I_ld_waddr] <= 1'b0;
      end
      if (w_issue_ok) begin
        r_busy[bus.I_ld_issue_addr] <= 1'b1;
      end
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data   <= {(NRD*XLEN){1'b0}};
      r_rd_hazard <= {NRD{1'b0}};
    end else if (bus.I_en) begin
      r_rd_data   <= w_rd_data;
      r_rd_hazard <= w_rd_hazard;
    end
  end

  assign bus.O_rd_data   = r_rd_data;
  assign bus.O_rd_hazard = r_rd_hazard;
  assign bus.O_busy      = r_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed, table-driven bench for reg_file_mp with hand sequences for
// asynchronous reset and enable hold.
module tb_reg_file_mp;
  localparam int XLEN = 32, NREGS = 32, ADDR_W = 5, NRD = 2;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .NRD(NRD)) bus ();

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .NRD(NRD),
                .RESET_INIT(1'b1), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  ra0, ra1;
    logic        alu_we;
    logic [4:0]  alu_a;
    logic [31:0] alu_d;
    logic        ld_we;
    logic [4:0]  ld_a;
    logic [31:0] ld_d;
    logic        iss;
    logic [4:0]  iss_a;
    logic [31:0] e_d0, e_d1;
    logic [1:0]  e_h;
    int          b_idx;
    logic        e_b;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.I_en            = v.en;
    bus.I_rd_addr       = {v.ra1, v.ra0};
    bus.I_alu_we        = v.alu_we;
    bus.I_alu_waddr     = v.alu_a;
    bus.I_alu_wdata     = v.alu_d;
    bus.I_ld_we         = v.ld_we;
    bus.I_ld_waddr      = v.ld_a;
    bus.I_ld_wdata      = v.ld_d;
    bus.I_ld_issue      = v.iss;
    bus.I_ld_issue_addr = v.iss_a;
  endtask

  task automatic idle(input logic en, input logic [4:0] ra0, input logic [4:0] ra1);
    vec_t v;
    v = '{en, ra0, ra1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
          32'h0, 32'h0, 2'b00, 0, 1'b0};
    drive(v);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //        en   ra0    ra1    awe   aa     ad            lwe   la     ld            iss   ia     e_d0          e_d1          e_h    bi  eb
    tbl[0]  = '{1'b1, 5'd3,  5'd31, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h3,        32'h1F,       2'b00, 9,  1'b0};
    tbl[1]  = '{1'b1, 5'd5,  5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 5,  1'b0};
    tbl[2]  = '{1'b1, 5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 5,  1'b0};
    tbl[3]  = '{1'b1, 5'd7,  5'd7,  1'b1, 5'd7,  32'h11,       1'b1, 5'd7,  32'h22,       1'b0, 5'd0,  32'h22,       32'h22,       2'b00, 7,  1'b0};
    tbl[4]  = '{1'b1, 5'd7,  5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h22,       32'h3,        2'b00, 7,  1'b0};
    tbl[5]  = '{1'b1, 5'd0,  5'd0,  1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  32'h0,        32'h0,        2'b00, 0,  1'b0};
    tbl[6]  = '{1'b1, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        2'b00, 0,  1'b0};
    tbl[7]  = '{1'b1, 5'd9,  5'd9,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h9,        32'h9,        2'b00, 9,  1'b1};
    tbl[8]  = '{1'b1, 5'd9,  5'd9,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h9,        32'h9,        2'b11, 9,  1'b1};
    tbl[9]  = '{1'b1, 5'd9,  5'd9,  1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'hABCD,     1'b0, 5'd0,  32'hABCD,     32'hABCD,     2'b00, 9,  1'b0};
    tbl[10] = '{1'b1, 5'd9,  5'd10, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h1234,     1'b1, 5'd9,  32'h1234,     32'hA,        2'b00, 9,  1'b1};
    tbl[11] = '{1'b1, 5'd9,  5'd9,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h1234,     32'h1234,     2'b11, 9,  1'b1};
    tbl[12] = '{1'b1, 5'd9,  5'd1,  1'b1, 5'd9,  32'h5555,     1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h5555,     32'h1,        2'b01, 9,  1'b1};
    tbl[13] = '{1'b0, 5'd3,  5'd4,  1'b1, 5'd5,  32'h77,       1'b1, 5'd9,  32'h88,       1'b1, 5'd10, 32'h5555,     32'h1,        2'b01, 10, 1'b0};

    rst = 1'b1;
    idle(1'b0, 5'd0, 5'd0);
    #2;
    check("reset_rd_data0", bus.O_rd_data[31:0], 32'h0);
    check("reset_rd_data1", bus.O_rd_data[63:32], 32'h0);
    check("reset_busy", bus.O_busy, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 14; k++) begin
      drive(tbl[k]);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_d0", k), bus.O_rd_data[31:0], tbl[k].e_d0);
      check($sformatf("v%0d_d1", k), bus.O_rd_data[63:32], tbl[k].e_d1);
      check($sformatf("v%0d_haz", k), {30'h0, bus.O_rd_hazard}, {30'h0, tbl[k].e_h});
      check($sformatf("v%0d_busy", k), {31'h0, bus.O_busy[tbl[k].b_idx]}, {31'h0, tbl[k].e_b});
    end
    check("pre_reset_busy9", {31'h0, bus.O_busy[9]}, 32'h1);

    // Asynchronous reset mid-sequence: outputs clear with no clock edge.
    idle(1'b1, 5'd5, 5'd9);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_d0", bus.O_rd_data[31:0], 32'h0);
    check("async_rst_d1", bus.O_rd_data[63:32], 32'h0);
    check("async_rst_haz", {30'h0, bus.O_rd_hazard}, 32'h0);
    check("async_rst_busy", bus.O_busy, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Enable held low with writes and an issue pending: nothing changes.
    bus.I_en            = 1'b0;
    bus.I_rd_addr       = {5'd9, 5'd5};
    bus.I_alu_we        = 1'b1;
    bus.I_alu_waddr     = 5'd5;
    bus.I_alu_wdata     = 32'hCAFEF00D;
    bus.I_ld_we         = 1'b1;
    bus.I_ld_waddr      = 5'd5;
    bus.I_ld_wdata      = 32'h0BADF00D;
    bus.I_ld_issue      = 1'b1;
    bus.I_ld_issue_addr = 5'd5;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold%0d_d0", c), bus.O_rd_data[31:0], 32'h0);
      check($sformatf("hold%0d_busy", c), bus.O_busy, 32'h0);
    end

    idle(1'b1, 5'd5, 5'd9);
    @(posedge clk);
    @(negedge clk);
    check("post_rst_r5", bus.O_rd_data[31:0], 32'h5);
    check("post_rst_r9", bus.O_rd_data[63:32], 32'h9);
    check("post_rst_haz", {30'h0, bus.O_rd_hazard}, 32'h0);
    check("post_rst_busy", bus.O_busy, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
